// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared types and constants for the iterative divider.
//               - div_state_t : divider FSM state encoding
//               - DIV_WIDTH   : default operand/result width
//               - DIV_LATENCY : cycles from the accepting edge to done
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int DIV_WIDTH   = 32;
    localparam int DIV_LATENCY = DIV_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One restoring-division step (combinational).
//               Shifts the partial remainder left by one, bringing in the
//               next dividend bit, and trial-subtracts the divisor.
// Ports       : rem       in  WIDTH  current partial remainder
//               dvd_msb   in  1      dividend bit shifted in this step
//               divisor   in  WIDTH  divisor magnitude
//               rem_next  out WIDTH  partial remainder after this step
//               q_bit     out 1      quotient bit produced by this step
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    // The shifted remainder can reach 2*divisor-1, so it needs WIDTH+1 bits;
    // the difference carries one more bit purely as the borrow/sign flag.
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH+1:0] w_diff;

    always_comb begin
        w_shifted = {rem, dvd_msb};
        w_diff    = {1'b0, w_shifted} - {2'b00, divisor};
        q_bit     = ~w_diff[WIDTH+1];
        // Either branch is below the divisor here, so the top bit is zero.
        rem_next  = WIDTH'(q_bit ? w_diff[WIDTH:0] : w_shifted);
    end

endmodule : div_step
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Multi-cycle signed/unsigned integer divider.
//               Restoring division on operand magnitudes, one quotient bit
//               per cycle, followed by a single sign-correction cycle.
// Ports       : clk          in  1      rising-edge clock
//               rst          in  1      synchronous active-high reset
//               start        in  1      request a division (IDLE only)
//               is_signed    in  1      1 = signed DIV, 0 = DIVU
//               dividend     in  WIDTH  numerator
//               divisor      in  WIDTH  denominator
//               busy         out 1      operation in progress (RUN/FIX)
//               done         out 1      one-cycle result-valid pulse
//               quotient     out WIDTH  result quotient
//               remainder    out WIDTH  result remainder
//               div_by_zero  out 1      divisor was zero
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    div_state_t         r_state;
    div_state_t         w_state_next;

    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_rem;          // partial remainder
    logic [WIDTH-1:0]   r_dvd;          // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]   r_dsr;          // divisor magnitude
    logic [WIDTH-1:0]   r_dividend_raw; // original dividend, for divide-by-zero
    logic               r_is_signed;
    logic               r_dvd_neg;
    logic               r_dsr_neg;
    logic               r_dsr_zero;

    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_div_by_zero;

    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]   w_dsr_mag;
    logic [WIDTH-1:0]   w_step_rem;
    logic               w_step_qbit;
    logic [WIDTH-1:0]   w_fix_q;
    logic [WIDTH-1:0]   w_fix_r;

    // ------------------------------------------------------------------------
    // Single restoring step
    // ------------------------------------------------------------------------
    div_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .rem     (r_rem),
        .dvd_msb (r_dvd[WIDTH-1]),
        .divisor (r_dsr),
        .rem_next(w_step_rem),
        .q_bit   (w_step_qbit)
    );

    // ------------------------------------------------------------------------
    // Operand magnitudes. The most negative value negates to itself, which is
    // still the correct unsigned magnitude.
    // ------------------------------------------------------------------------
    always_comb begin
        w_dvd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
        w_dsr_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    end

    // ------------------------------------------------------------------------
    // Sign correction applied during FIX. Divide-by-zero bypasses the signed
    // fix-up so the quotient is all-ones and the remainder the raw dividend
    // regardless of operand signs.
    // ------------------------------------------------------------------------
    always_comb begin
        w_fix_q = (r_is_signed && (r_dvd_neg ^ r_dsr_neg)) ? -r_dvd : r_dvd;
        w_fix_r = (r_is_signed && r_dvd_neg) ? -r_rem : r_rem;
        if (r_dsr_zero) begin
            w_fix_q = '1;
            w_fix_r = r_dividend_raw;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and status outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                // The last step is the one that sees the counter at 1.
                if (r_count == c_CNT_W'(1)) begin
                    w_state_next = FIX;
                end
            end
            FIX: begin
                busy         = 1'b1;
                w_state_next = DONE;
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count        <= '0;
            r_rem          <= '0;
            r_dvd          <= '0;
            r_dsr          <= '0;
            r_dividend_raw <= '0;
            r_is_signed    <= 1'b0;
            r_dvd_neg      <= 1'b0;
            r_dsr_neg      <= 1'b0;
            r_dsr_zero     <= 1'b0;
            r_quotient     <= '0;
            r_remainder    <= '0;
            r_div_by_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_count        <= c_CNT_W'(WIDTH);
                        r_rem          <= '0;
                        r_dvd          <= w_dvd_mag;
                        r_dsr          <= w_dsr_mag;
                        r_dividend_raw <= dividend;
                        r_is_signed    <= is_signed;
                        r_dvd_neg      <= is_signed & dividend[WIDTH-1];
                        r_dsr_neg      <= is_signed & divisor[WIDTH-1];
                        r_dsr_zero     <= (divisor == '0);
                    end
                end
                RUN: begin
                    r_rem   <= w_step_rem;
                    r_dvd   <= {r_dvd[WIDTH-2:0], w_step_qbit};
                    r_count <= r_count - c_CNT_W'(1);
                end
                FIX: begin
                    // Results change only on the edge entering DONE.
                    r_quotient    <= w_fix_q;
                    r_remainder   <= w_fix_r;
                    r_div_by_zero <= r_dsr_zero;
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule : div_unit
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Self-checking bench for div_unit. A driver issues directed
//               and random divisions and queues the expected results; a
//               monitor compares them when done pulses and checks that the
//               result outputs hold between operations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;
    import div_pkg::*;

    localparam int W = DIV_WIDTH;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           t0;
    } exp_t;

    exp_t         sb[$];
    int           n_vec = 0;
    int           n_bad = 0;
    bit           in_reset = 1'b1;
    logic [W-1:0] hold_q = '0;
    logic [W-1:0] hold_r = '0;
    logic         hold_dz = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division with the architectural special cases.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t   e;
        longint da, db, qq, rr;
        e.t0 = 0;
        e.dz = (b == '0);
        if (b == '0) begin
            e.q = '1;
            e.r = a;
        end else begin
            if (s) begin
                da = longint'($signed(a));
                db = longint'($signed(b));
            end else begin
                da = longint'({32'b0, a});
                db = longint'({32'b0, b});
            end
            qq  = da / db;     // truncates toward zero; -2^31/-1 = 2^31 wraps
            rr  = da % db;     // sign follows the dividend
            e.q = qq[W-1:0];
            e.r = rr[W-1:0];
        end
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = W'(1);
            2:       v = '1;
            3:       v = {1'b1, {(W-1){1'b0}}};
            4:       v = {1'b0, {(W-1){1'b1}}};
            5:       v = W'($urandom_range(0, 255));
            6:       v = -W'($urandom_range(1, 255));
            default: v = W'($urandom());
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    always @(negedge clk) begin : mon
        exp_t e;
        if (!in_reset) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 128'(done), 128'(0));
                end else begin
                    e = sb.pop_front();
                    check("quotient",    128'(quotient),    128'(e.q));
                    check("remainder",   128'(remainder),   128'(e.r));
                    check("div_by_zero", 128'(div_by_zero), 128'(e.dz));
                    check("latency",     128'(cyc - e.t0),  128'(DIV_LATENCY));
                    check("busy_in_done", 128'(busy),       128'(0));
                    hold_q  = e.q;
                    hold_r  = e.r;
                    hold_dz = e.dz;
                end
            end else begin
                check("result_hold", {quotient, remainder, div_by_zero},
                      {hold_q, hold_r, hold_dz});
            end
        end
    end

    // ------------------------------------------------------------------------
    // Driver (all tasks start and end just after a falling edge)
    // ------------------------------------------------------------------------
    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("idle_timeout", 128'(busy), 128'(0));
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input exp_t e);
        exp_t x;
        wait_idle();
        start     = 1'b1;
        dividend  = a;
        divisor   = b;
        is_signed = s;
        x         = e;
        x.t0      = cyc;
        sb.push_back(x);
        @(negedge clk);
        start     = 1'b0;
        dividend  = W'($urandom());
        divisor   = W'($urandom());
        is_signed = 1'($urandom_range(0, 1));
        check("busy_after_start", 128'(busy), 128'(1));
    endtask

    task automatic issue_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        drive(a, b, s, model(a, b, s));
    endtask

    task automatic issue_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                             input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
        exp_t e;
        e.q  = q;
        e.r  = r;
        e.dz = dz;
        e.t0 = 0;
        drive(a, b, s, e);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst      = 1'b1;
        in_reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state", {busy, done, quotient, remainder, div_by_zero}, 128'(0));
        rst      = 1'b0;
        in_reset = 1'b0;
        @(negedge clk);

        // Directed vectors with known answers
        issue_exp(32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0);
        issue_exp(-32'sd7,      32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        issue_exp(32'd7,        -32'sd2,      1'b1, 32'hFFFFFFFD, 32'd1,        1'b0);
        issue_exp(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b0);
        issue_exp(32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 32'd0,        1'b0);
        issue_exp(32'h1234,     32'd0,        1'b0, 32'hFFFFFFFF, 32'h1234,     1'b1);
        issue_exp(32'hFFFFFFFB, 32'd0,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1);
        issue_exp(32'd0,        32'd5,        1'b1, 32'd0,        32'd0,        1'b0);
        issue_exp(32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 32'd0,        32'hFFFFFFFE, 1'b0);

        // start pulses during a running op are ignored
        issue_exp(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        repeat (3) @(negedge clk);
        start = 1'b1; dividend = 32'd999; divisor = 32'd3; is_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        start = 1'b1; dividend = 32'd55; divisor = 32'd11; is_signed = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Reset aborts an op in RUN; a new op is accepted right after
        wait_idle();
        issue_model(32'h5555, 32'd3, 1'b0);
        repeat (8) @(negedge clk);
        rst      = 1'b1;
        in_reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        hold_q   = '0;
        hold_r   = '0;
        hold_dz  = 1'b0;
        rst      = 1'b0;
        in_reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        issue_exp(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);

        // Random operands checked against the reference model
        for (int i = 0; i < 40; i++) begin
            issue_model(pick(), pick(), 1'($urandom_range(0, 1)));
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 128'(sb.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_div_unit
`default_nettype wire
